// File: rtl/tpu_pkg.sv
// Shared tpumac definitions: default operand/array sizes, feeder state encoding,
// and a helper that locates lane/column slices in flattened packed vectors.
package tpu_pkg;

  localparam int TPU_BITS_AB = 8;
  localparam int TPU_DIM     = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } feeder_state_t;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_a_skew_feeder.sv
// Buffers a DIM x DIM tile of signed A operands and streams it diagonally skewed
// into the systolic array's left edge, advancing only on the shared en stall.
module systolic_a_skew_feeder
  import tpu_pkg::*;
#(
  parameter  int BITS_AB = TPU_BITS_AB,
  parameter  int DIM     = TPU_DIM,
  localparam int ADDR_W  = $clog2(DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     WrEn,
  input  logic [ADDR_W-1:0]        Row_addr,
  input  logic [DIM*BITS_AB-1:0]   Ain_row,
  input  logic                     start,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic                     busy,
  output logic                     done
);

  localparam int             T_W    = $clog2(2*DIM-1);
  localparam logic [T_W-1:0] T_LAST = T_W'(2*DIM-2);

  logic signed [BITS_AB-1:0] mem_q [DIM][DIM];
  feeder_state_t             state_q, state_d;
  logic [T_W-1:0]            t_q, t_d;
  logic [DIM*BITS_AB-1:0]    aout_q, aout_d;
  logic [DIM*BITS_AB-1:0]    slice;
  logic                      done_q, done_d;
  logic                      wr_ok;

  // Tile is frozen while streaming; rows beyond DIM never match any r below.
  assign wr_ok = WrEn && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mem_q[r][c] <= '0;
    end else if (wr_ok) begin
      for (int r = 0; r < DIM; r++)
        if (int'(Row_addr) == r)
          for (int c = 0; c < DIM; c++)
            mem_q[r][c] <= Ain_row[lane_lsb(c, BITS_AB) +: BITS_AB];
    end
  end

  // Lane i carries column t-i of row i while that column exists, zero otherwise.
  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [ADDR_W-1:0] idx;
    logic              sel;
    assign idx = ADDR_W'(t_q - T_W'(i));
    assign sel = (int'(t_q) >= i) && ((int'(t_q) - i) < DIM);
    assign slice[lane_lsb(i, BITS_AB) +: BITS_AB] = sel ? mem_q[i][idx] : '0;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    aout_d  = aout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) aout_d = '0;
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (en) begin
          aout_d = slice;
          t_d    = t_q + 1'b1;
          if (t_q == T_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      aout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      aout_q  <= aout_d;
      done_q  <= done_d;
    end
  end

  assign Aout = aout_q;
  assign busy = (state_q == STREAM);
  assign done = done_q;

endmodule

// File: tb/tb_systolic_a_skew_feeder.sv
// Directed and randomized checks of the skew feeder against a tile-array model:
// slice k, lane i = tile[i][k-i] when that column exists, else zero.
module tb_systolic_a_skew_feeder;

  localparam int BITS  = 8;
  localparam int DIM   = 4;
  localparam int STEPS = 2*DIM-1;
  localparam int W     = DIM*BITS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          WrEn;
  logic [1:0]    Row_addr;
  logic [W-1:0]  Ain_row;
  logic          start;
  logic [W-1:0]  Aout;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int tile [DIM][DIM];

  systolic_a_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn), .Row_addr(Row_addr),
    .Ain_row(Ain_row), .start(start), .Aout(Aout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    logic [W-1:0] v;
    v[0*BITS +: BITS] = BITS'(a0);
    v[1*BITS +: BITS] = BITS'(a1);
    v[2*BITS +: BITS] = BITS'(a2);
    v[3*BITS +: BITS] = BITS'(a3);
    return v;
  endfunction

  // Expected skewed slice for stream step k, straight from the tile model.
  function automatic logic [W-1:0] expect_slice(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++)
      if (k - i >= 0 && k - i < DIM)
        v[i*BITS +: BITS] = BITS'(tile[i][k-i]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_row(input int r, input logic [W-1:0] row);
    for (int c = 0; c < DIM; c++)
      tile[r][c] = int'($signed(row[c*BITS +: BITS]));
  endtask

  task automatic write_row(input int r, input logic [W-1:0] row);
    WrEn = 1'b1; Row_addr = 2'(r); Ain_row = row;
    tick();
    WrEn = 1'b0;
    model_row(r, row);
  endtask

  // Runs one stream; optional stall after step stall_at, write attempt while
  // busy, and a start pulse coinciding with the final edge.
  task automatic run_stream(input string tag, input int stall_at, input int stall_len,
                            input bit busy_wr, input bit late_start);
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " entry busy"}, 64'(busy), 64'd1);
    check({tag, " entry aout"}, 64'(Aout), 64'd0);
    for (int k = 0; k < STEPS; k++) begin
      en = 1'b1;
      if (busy_wr && k == 2) begin
        WrEn = 1'b1; Row_addr = 2'd1; Ain_row = pack(99, 99, 99, 99);
      end
      if (late_start && k == STEPS-1) start = 1'b1;
      tick();
      WrEn = 1'b0; start = 1'b0;
      check($sformatf("%s step%0d aout", tag, k), 64'(Aout), 64'(expect_slice(k)));
      check($sformatf("%s step%0d done", tag, k), 64'(done), 64'(k == STEPS-1));
      check($sformatf("%s step%0d busy", tag, k), 64'(busy), 64'(k != STEPS-1));
      if (k == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check($sformatf("%s stall%0d aout", tag, s), 64'(Aout), 64'(expect_slice(k)));
          check($sformatf("%s stall%0d done", tag, s), 64'(done), 64'd0);
          check($sformatf("%s stall%0d busy", tag, s), 64'(busy), 64'd1);
        end
      end
    end
    en = 1'b1;
    tick();
    check({tag, " post aout"}, 64'(Aout), 64'd0);
    check({tag, " post done"}, 64'(done), 64'd0);
    check({tag, " post busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; WrEn = 1'b0; Row_addr = '0; Ain_row = '0; start = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        tile[r][c] = 0;

    // Asynchronous reset asserted mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check("reset aout", 64'(Aout), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_stream("empty", -1, 0, 1'b0, 1'b0);

    // A[i][j] = 4i+j+1, plain stream.
    for (int r = 0; r < DIM; r++)
      write_row(r, pack(4*r+1, 4*r+2, 4*r+3, 4*r+4));
    run_stream("full", -1, 0, 1'b0, 1'b0);

    // Three-cycle stall after step 2.
    run_stream("stall", 2, 3, 1'b0, 1'b0);

    // Writes during the stream are ignored; late start is ignored.
    run_stream("busywr", -1, 0, 1'b1, 1'b1);
    run_stream("rerun", -1, 0, 1'b0, 1'b0);

    // Write and start in the same IDLE cycle: stream sees the new row.
    en = 1'b1; WrEn = 1'b1; Row_addr = 2'd2; Ain_row = pack(-5, 6, -7, 8); start = 1'b1;
    model_row(2, pack(-5, 6, -7, 8));
    tick();
    WrEn = 1'b0; start = 1'b0;
    check("wrstart busy", 64'(busy), 64'd1);
    for (int k = 0; k < STEPS; k++) begin
      tick();
      check($sformatf("wrstart step%0d aout", k), 64'(Aout), 64'(expect_slice(k)));
    end
    tick();

    // Sign extremes on row 0, lane 0 bit-exact.
    write_row(0, pack(-128, 127, -1, 0));
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < STEPS; k++) begin
      tick();
      check($sformatf("sign step%0d aout", k), 64'(Aout), 64'(expect_slice(k)));
    end
    tick();

    // Reset in the middle of a stream clears everything including the tile.
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midrst pre aout", 64'(Aout), 64'(expect_slice(3)));
    #2 rst_n = 1'b0;
    #1;
    check("midrst aout", 64'(Aout), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        tile[r][c] = 0;
    tick();
    rst_n = 1'b1;
    tick();
    run_stream("postrst", -1, 0, 1'b0, 1'b0);

    // Randomized tiles and stall placement.
    for (int it = 0; it < 4; it++) begin
      for (int r = 0; r < DIM; r++)
        write_row(r, W'($urandom));
      run_stream($sformatf("rand%0d", it), int'($urandom_range(0, STEPS-2)),
                 int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
